// File: rtl/vram_port_arbiter_if.sv
// Port-A bundle of the text VRAM arbiter: clear engine, AXI requests, BRAM.
// addr_err is present only when VRAM_BOUNDS_CHECK_EN is defined.
interface vram_port_arbiter_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] init_addr;
  logic [3:0]        init_wren;
  logic [31:0]       init_data;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_strb;
  logic [31:0]       wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_data_valid;
  logic [31:0]       rd_data;

  logic              init_busy;

  logic [ADDR_W-1:0] bram_addr;
  logic [3:0]        bram_wren;
  logic [31:0]       bram_din;
  logic [31:0]       bram_dout;
`ifdef VRAM_BOUNDS_CHECK_EN
  logic              addr_err;
`endif

  modport slave (
    input  init_addr,
    input  init_wren,
    input  init_data,
    input  wr_valid,
    output wr_ready,
    input  wr_addr,
    input  wr_strb,
    input  wr_data,
    input  rd_valid,
    output rd_ready,
    input  rd_addr,
    output rd_data_valid,
    output rd_data,
    output init_busy,
    output bram_addr,
    output bram_wren,
    output bram_din,
`ifdef VRAM_BOUNDS_CHECK_EN
    output addr_err,
`endif
    input  bram_dout
  );

  modport master (
    output init_addr,
    output init_wren,
    output init_data,
    output wr_valid,
    input  wr_ready,
    output wr_addr,
    output wr_strb,
    output wr_data,
    output rd_valid,
    input  rd_ready,
    output rd_addr,
    input  rd_data_valid,
    input  rd_data,
    input  init_busy,
    input  bram_addr,
    input  bram_wren,
    input  bram_din,
`ifdef VRAM_BOUNDS_CHECK_EN
    input  addr_err,
`endif
    output bram_dout
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Text VRAM port-A arbiter: clear engine > buffered AXI write > AXI read.
// Optional VRAM_BOUNDS_CHECK_EN drops/zeroes out-of-range AXI accesses.
module vram_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int VRAM_WORDS = 600,
  parameter int RD_LATENCY = 2
) (
  input logic                clk,
  input logic                reset_n,
  vram_port_arbiter_if.slave bus
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              w_init_req;
  logic              w_init_busy;
  logic              w_wr_ready;
  logic              w_rd_ready;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_rd_pending;
  logic              w_sel_init;
  logic              w_sel_buf;
  logic              w_sel_rd;
  logic              w_wr_keep;
  logic              w_rd_zero;

  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [3:0]        r_buf_strb;
  logic [31:0]       r_buf_data;

  logic [RD_LATENCY:0] r_rd_pipe;

  logic [ADDR_W-1:0] r_bram_addr;
  logic [3:0]        r_bram_wren;
  logic [31:0]       r_bram_din;

  assign w_init_req = |bus.init_wren;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init_busy = 1'b0;
    w_wr_ready  = 1'b0;
    w_rd_ready  = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        w_init_busy = 1'b1;
        if (!w_init_req) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_wr_ready = !r_buf_valid;
        w_rd_ready = !r_buf_valid
                   && !w_rd_pending
                   && !bus.wr_valid;
        if (w_init_req) begin
          w_state_nxt = ST_INIT;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign w_wr_fire = bus.wr_valid && w_wr_ready;
  assign w_rd_fire = bus.rd_valid && w_rd_ready;

  // Fixed priority, one-hot by construction
  assign w_sel_init = w_init_req;
  assign w_sel_buf  = !w_init_req && r_buf_valid;
  assign w_sel_rd   = !w_init_req && !r_buf_valid
                    && w_rd_fire;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_strb  <= '0;
      r_buf_data  <= '0;
    end else if (w_wr_fire) begin
      r_buf_valid <= w_wr_keep;
      r_buf_addr  <= bus.wr_addr;
      r_buf_strb  <= bus.wr_strb;
      r_buf_data  <= bus.wr_data;
    end else if (w_sel_buf) begin
      r_buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_pipe <= '0;
    end else begin
      r_rd_pipe <= {r_rd_pipe[RD_LATENCY-1:0], w_rd_fire};
    end
  end

  assign w_rd_pending = |r_rd_pipe;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bram_addr <= '0;
      r_bram_wren <= '0;
      r_bram_din  <= '0;
    end else begin
      r_bram_wren <= '0;
      unique case (1'b1)
        w_sel_init: begin
          r_bram_addr <= bus.init_addr;
          r_bram_wren <= bus.init_wren;
          r_bram_din  <= bus.init_data;
        end
        w_sel_buf: begin
          r_bram_addr <= r_buf_addr;
          r_bram_wren <= r_buf_strb;
          r_bram_din  <= r_buf_data;
        end
        w_sel_rd: begin
          r_bram_addr <= bus.rd_addr;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef VRAM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] LP_LIMIT = ADDR_W'(VRAM_WORDS);

  logic w_wr_oob;
  logic w_rd_oob;
  logic r_rd_oob;
  logic r_addr_err;

  assign w_wr_oob = bus.wr_addr >= LP_LIMIT;
  assign w_rd_oob = bus.rd_addr >= LP_LIMIT;

  // One read outstanding at most, so a single flag tracks it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_oob   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_rd_fire) begin
        r_rd_oob <= w_rd_oob;
      end
      if ((w_wr_fire && w_wr_oob)
          || (w_rd_fire && w_rd_oob)) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign w_wr_keep    = !w_wr_oob;
  assign w_rd_zero    = r_rd_oob;
  assign bus.addr_err = r_addr_err;
`else
  assign w_wr_keep = 1'b1;
  assign w_rd_zero = 1'b0;
`endif

  assign bus.wr_ready      = w_wr_ready;
  assign bus.rd_ready      = w_rd_ready;
  assign bus.init_busy     = w_init_busy;
  assign bus.rd_data_valid = r_rd_pipe[RD_LATENCY];
  assign bus.rd_data       = (r_rd_pipe[RD_LATENCY] && !w_rd_zero)
                           ? bus.bram_dout : '0;
  assign bus.bram_addr     = r_bram_addr;
  assign bus.bram_wren     = r_bram_wren;
  assign bus.bram_din      = r_bram_din;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed + random bench for vram_port_arbiter with a word-array VRAM model.
// Define VRAM_BOUNDS_CHECK_EN to exercise the bounds-check build.
module tb_vram_port_arbiter;
  localparam int ADDR_W     = 11;
  localparam int VRAM_WORDS = 600;
  localparam int RD_LATENCY = 2;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  vram_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  vram_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .VRAM_WORDS(VRAM_WORDS),
    .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0]  s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // BRAM model: 2-cycle read latency from address presentation
  logic [31:0] bram_mem [0:2047];
  logic [31:0] q1, q2;
  always @(posedge clk) begin
    if (|bus.bram_wren) begin
      bram_mem[bus.bram_addr] <= merge(bram_mem[bus.bram_addr],
                                       bus.bram_din, bus.bram_wren);
    end
    q1 <= bram_mem[bus.bram_addr];
    q2 <= q1;
  end
  assign bus.bram_dout = q2;

  // Reference VRAM contents as seen by the AXI side
  logic [31:0] ref_mem [0:2047];

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] d;
  logic [31:0] d9;
  bit          acc;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'(0));
    check({tag, "_rd_ready"}, 32'(bus.rd_ready), 32'(0));
    check({tag, "_rd_dv"},    32'(bus.rd_data_valid), 32'(0));
    check({tag, "_rd_data"},  bus.rd_data, 32'(0));
    check({tag, "_busy"},     32'(bus.init_busy), 32'(1));
    check({tag, "_baddr"},    32'(bus.bram_addr), 32'(0));
    check({tag, "_bwren"},    32'(bus.bram_wren), 32'(0));
    check({tag, "_bdin"},     bus.bram_din, 32'(0));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 of the cycle after read acceptance
  task automatic wait_return(input logic [ADDR_W-1:0] a,
                             input logic [31:0] exp,
                             input string tag);
    int lat;
    logic [31:0] got;
    lat = 0;
    got = 'x;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (j == 1) begin
        check({tag, "_baddr"}, 32'(bus.bram_addr), 32'(a));
        check({tag, "_bwren"}, 32'(bus.bram_wren), 32'(0));
      end
      if (bus.rd_data_valid) begin
        lat = j;
        got = bus.rd_data;
        break;
      end
      nxt();
    end
    check({tag, "_lat"}, 32'(lat), 32'(RD_LATENCY + 1));
    check({tag, "_data"}, got, exp);
    nxt();
  endtask

  task automatic axi_read(input logic [ADDR_W-1:0] a,
                          input logic [31:0] exp,
                          input string tag);
    bit ok;
    ok = 0;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = a;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rd_ready) begin
        ok = 1;
        break;
      end
      nxt();
    end
    check({tag, "_acc"}, 32'(ok), 32'(1));
    nxt();
    bus.rd_valid = 1'b0;
    if (ok) wait_return(a, exp, tag);
  endtask

  task automatic axi_write(input logic [ADDR_W-1:0] a,
                           input logic [3:0]  s,
                           input logic [31:0] dd,
                           input bit          issue,
                           input string       tag);
    bit ok;
    ok = 0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_strb  = s;
    bus.wr_data  = dd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.wr_ready) begin
        ok = 1;
        break;
      end
      nxt();
    end
    check({tag, "_acc"}, 32'(ok), 32'(1));
    nxt();
    bus.wr_valid = 1'b0;
    if (ok && issue) ref_mem[a] = merge(ref_mem[a], dd, s);
    @(negedge clk);
    check({tag, "_rdy1"}, 32'(bus.wr_ready), 32'(!issue));
    check({tag, "_bw1"}, 32'(bus.bram_wren), 32'(0));
    nxt();
    @(negedge clk);
    if (issue) begin
      check({tag, "_bwren"}, 32'(bus.bram_wren), 32'(s));
      check({tag, "_baddr"}, 32'(bus.bram_addr), 32'(a));
      check({tag, "_bdin"},  bus.bram_din, dd);
    end else begin
      check({tag, "_bwren"}, 32'(bus.bram_wren), 32'(0));
    end
    nxt();
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.init_addr = '0;
    bus.init_wren = '0;
    bus.init_data = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_strb   = '0;
    bus.wr_data   = '0;
    bus.rd_valid  = 1'b0;
    bus.rd_addr   = '0;

    repeat (3) nxt();
    @(negedge clk);
    chk_reset("rst");
`ifdef VRAM_BOUNDS_CHECK_EN
    check("rst_aerr", 32'(bus.addr_err), 32'(0));
`endif
    nxt();
    reset_n = 1'b1;

    // Clear sweep over the whole VRAM
    for (int i = 0; i < VRAM_WORDS; i++) begin
      d = $urandom;
      bus.init_addr = ADDR_W'(i);
      bus.init_wren = 4'hF;
      bus.init_data = d;
      ref_mem[i]    = d;
      @(negedge clk);
      check("clr_busy", 32'(bus.init_busy), 32'(1));
      check("clr_wr_rdy", 32'(bus.wr_ready), 32'(0));
      check("clr_rd_rdy", 32'(bus.rd_ready), 32'(0));
      if (i == 0) begin
        check("clr_first_bw", 32'(bus.bram_wren), 32'(0));
      end else begin
        check("clr_bwren", 32'(bus.bram_wren), 32'(4'hF));
        check("clr_baddr", 32'(bus.bram_addr), 32'(i - 1));
        check("clr_bdin", bus.bram_din, ref_mem[i-1]);
      end
      nxt();
    end
    bus.init_wren = '0;
    @(negedge clk);
    check("clr_last_addr", 32'(bus.bram_addr), 32'(VRAM_WORDS - 1));
    check("clr_last_wren", 32'(bus.bram_wren), 32'(4'hF));
    check("clr_last_busy", 32'(bus.init_busy), 32'(1));
    check("clr_last_wrdy", 32'(bus.wr_ready), 32'(0));
    nxt();
    @(negedge clk);
    check("run_busy", 32'(bus.init_busy), 32'(0));
    check("run_bwren", 32'(bus.bram_wren), 32'(0));
    check("run_wr_rdy", 32'(bus.wr_ready), 32'(1));
    check("run_rd_rdy", 32'(bus.rd_ready), 32'(1));
    nxt();

    // Partial-strobe write, 2-cycle latency
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 11'd5;
    bus.wr_strb  = 4'h3;
    bus.wr_data  = 32'hDEADBEEF;
    @(negedge clk);
    check("w5_rdy0", 32'(bus.wr_ready), 32'(1));
    nxt();
    bus.wr_valid = 1'b0;
    ref_mem[5] = merge(ref_mem[5], 32'hDEADBEEF, 4'h3);
    @(negedge clk);
    check("w5_rdy1", 32'(bus.wr_ready), 32'(0));
    check("w5_bw1", 32'(bus.bram_wren), 32'(0));
    nxt();
    @(negedge clk);
    check("w5_rdy2", 32'(bus.wr_ready), 32'(1));
    check("w5_bwren", 32'(bus.bram_wren), 32'(4'h3));
    check("w5_baddr", 32'(bus.bram_addr), 32'(5));
    check("w5_bdin", bus.bram_din, 32'hDEADBEEF);
    nxt();
    axi_read(11'd5, ref_mem[5], "r5");

    // Read-after-write to the same address
    d = $urandom;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 11'd7;
    bus.wr_strb  = 4'hF;
    bus.wr_data  = d;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 11'd7;
    @(negedge clk);
    check("raw_wrdy", 32'(bus.wr_ready), 32'(1));
    check("raw_blk0", 32'(bus.rd_ready), 32'(0));
    nxt();
    bus.wr_valid = 1'b0;
    ref_mem[7] = d;
    @(negedge clk);
    check("raw_blk1", 32'(bus.rd_ready), 32'(0));
    nxt();
    @(negedge clk);
    check("raw_bwren", 32'(bus.bram_wren), 32'(4'hF));
    check("raw_baddr", 32'(bus.bram_addr), 32'(7));
    check("raw_acc", 32'(bus.rd_ready), 32'(1));
    nxt();
    bus.rd_valid = 1'b0;
    wait_return(11'd7, d, "raw_rd");

    // Re-clear while a write sits in the buffer
    d9 = $urandom;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 11'd9;
    bus.wr_strb  = 4'hF;
    bus.wr_data  = d9;
    @(negedge clk);
    check("rc_wrdy", 32'(bus.wr_ready), 32'(1));
    nxt();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      bus.init_addr = ADDR_W'(100 + i);
      bus.init_wren = 4'hF;
      bus.init_data = d;
      ref_mem[100+i] = d;
      @(negedge clk);
      check("rc_wrdy_lo", 32'(bus.wr_ready), 32'(0));
      if (i == 0) begin
        check("rc_busy0", 32'(bus.init_busy), 32'(0));
        check("rc_bw0", 32'(bus.bram_wren), 32'(0));
      end else begin
        check("rc_busy", 32'(bus.init_busy), 32'(1));
        check("rc_baddr", 32'(bus.bram_addr), 32'(100 + i - 1));
        check("rc_bwren", 32'(bus.bram_wren), 32'(4'hF));
      end
      nxt();
    end
    bus.init_wren = '0;
    @(negedge clk);
    check("rc_last_addr", 32'(bus.bram_addr), 32'(103));
    check("rc_last_busy", 32'(bus.init_busy), 32'(1));
    nxt();
    @(negedge clk);
    check("rc_buf_bwren", 32'(bus.bram_wren), 32'(4'hF));
    check("rc_buf_baddr", 32'(bus.bram_addr), 32'(9));
    check("rc_buf_bdin", bus.bram_din, d9);
    check("rc_buf_busy", 32'(bus.init_busy), 32'(0));
    nxt();
    ref_mem[9] = d9;
    axi_read(11'd9, ref_mem[9], "rc_r9");
    axi_read(11'd101, ref_mem[101], "rc_r101");

    // Random traffic against the reference memory
    for (int n = 0; n < 150; n++) begin
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom_range(0, VRAM_WORDS - 1));
      if ($urandom_range(0, 1) == 1) begin
        axi_write(a, 4'($urandom_range(1, 15)), $urandom, 1'b1, "rnd_wr");
      end else begin
        axi_read(a, ref_mem[a], "rnd_rd");
      end
      repeat ($urandom_range(0, 2)) nxt();
    end

`ifdef VRAM_BOUNDS_CHECK_EN
    check("oob_pre_aerr", 32'(bus.addr_err), 32'(0));
    axi_write(11'd600, 4'hF, 32'h12345678, 1'b0, "oob_wr");
    check("oob_wr_aerr", 32'(bus.addr_err), 32'(1));
    axi_read(11'd700, 32'(0), "oob_rd");
    check("oob_rd_aerr", 32'(bus.addr_err), 32'(1));
`else
    d = $urandom;
    axi_write(11'd600, 4'hF, d, 1'b1, "hi_wr");
    axi_read(11'd600, ref_mem[600], "hi_rd");
`endif

    // Reset one cycle after a read is accepted
    bus.rd_valid = 1'b1;
    bus.rd_addr  = 11'd42;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rd_ready) begin
        acc = 1;
        break;
      end
      nxt();
    end
    check("mr_acc", 32'(acc), 32'(1));
    nxt();
    bus.rd_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check("mr_dv0", 32'(bus.rd_data_valid), 32'(0));
    nxt();
    @(negedge clk);
    chk_reset("mr");
`ifdef VRAM_BOUNDS_CHECK_EN
    check("mr_aerr", 32'(bus.addr_err), 32'(0));
`endif
    for (int k = 0; k < 4; k++) begin
      nxt();
      @(negedge clk);
      check("mr_no_dv", 32'(bus.rd_data_valid), 32'(0));
    end
    nxt();
    reset_n = 1'b1;
    @(negedge clk);
    check("mr_rel_busy", 32'(bus.init_busy), 32'(1));
    nxt();
    @(negedge clk);
    check("mr_run_busy", 32'(bus.init_busy), 32'(0));
    nxt();
    axi_read(11'd42, ref_mem[42], "mr_r42");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Owns write/read port A of the 600-word text VRAM (80x30 chars, 4 chars per 32-bit word).
- Sits directly downstream of the VRAM clear engine and merges that engine's addr/wren/data stream with AXI-side register-file accesses.
- Arbitration is fixed priority: clear-engine writes, then buffered AXI write, then AXI read.
- All BRAM-facing signals are registered, so the BRAM port sees a clean one-cycle-delayed command stream.

Parameters:
- ADDR_W, 11, VRAM word address width.
- VRAM_WORDS, 600, number of valid VRAM words.
- RD_LATENCY, 2, BRAM read latency in cycles, counted from the cycle bram_addr is presented to the cycle bram_dout is valid.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- init_addr  in  ADDR_W  clear-engine word address.
- init_wren  in  4  clear-engine byte write enables; any bit set means a clear write.
- init_data  in  32  clear-engine write data.
- wr_valid  in  1  AXI write request valid.
- wr_ready  out  1  AXI write request ready.
- wr_addr  in  ADDR_W  AXI write word address.
- wr_strb  in  4  AXI byte strobes.
- wr_data  in  32  AXI write data.
- rd_valid  in  1  AXI read request valid.
- rd_ready  out  1  AXI read request ready.
- rd_addr  in  ADDR_W  AXI read word address.
- rd_data_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  32  read return data.
- init_busy  out  1  high while the clear sequence owns the port.
- bram_addr  out  ADDR_W  registered BRAM address.
- bram_wren  out  4  registered BRAM byte write enables.
- bram_din  out  32  registered BRAM write data.
- bram_dout  in  32  BRAM read data.

Behaviour:
- Reset values: wr_ready=0, rd_ready=0, rd_data_valid=0, rd_data=0, init_busy=1, bram_addr=0, bram_wren=0, bram_din=0. Reset also clears the write buffer and the read pipeline, and forces state ST_INIT.
- State machine:
  - ST_INIT: stays while init_wren!=0. Moves to ST_RUN on the first cycle with init_wren==0. init_busy=1; wr_ready=0; rd_ready=0.
  - ST_RUN: init_busy=0. If init_wren!=0 again, go back to ST_INIT (re-clear); the buffered write is held, not dropped.
- Write buffer: single entry holding addr, strb and data.
  - wr_ready = (state==ST_RUN) && !buf_valid.
  - Handshake fires on wr_valid && wr_ready; the buffer loads on that edge.
- Per-cycle selection; the winner is registered onto bram_* at the next edge:
  - init_wren!=0: bram <= init_addr / init_wren / init_data.
  - else buf_valid: bram <= buffer contents; buf_valid clears on that edge.
  - else read accepted this cycle: bram_addr <= rd_addr, bram_wren <= 0.
  - else: bram_wren <= 0, bram_addr holds its value.
- Read acceptance:
  - rd_ready = (state==ST_RUN) && !buf_valid && !rd_pending && !wr_valid.
  - A buffered or incoming write therefore always reaches BRAM before a later read (read-after-write ordering).
- Read return:
  - Read accepted at cycle N: bram_addr is presented at N+1.
  - rd_data_valid pulses at N+1+RD_LATENCY with rd_data = bram_dout sampled that cycle.
  - rd_pending stays set until that pulse, so at most one read is outstanding.
- A clear write arriving while a read is in flight does not corrupt the return; the return still follows the fixed latency.
- Write latency: init input to bram_wren is 1 cycle. AXI handshake to bram_wren is 2 cycles when uncontended.
- Address width: addresses are passed through unmodified, with no wrap.
- Reset asserted mid-operation: the pending buffer and any in-flight read are discarded; no rd_data_valid is emitted.

Optional Feature:
- VRAM_BOUNDS_CHECK_EN defined:
  - AXI writes with wr_addr >= VRAM_WORDS are accepted (handshake completes) but never reach BRAM.
  - AXI reads with rd_addr >= VRAM_WORDS return rd_data=0 at the normal latency.
  - Either case sets a sticky output addr_err (1 bit, reset 0), cleared only by reset.
- Undefined: no checking, no addr_err port; all addresses are forwarded.

Test Plan:
- Release reset; clear engine drives wren=4'hF for addresses 0..599 -> bram_wren=4'hF for 600 consecutive cycles at addresses 0..599, each one cycle delayed. init_busy falls the cycle after init_wren drops. wr_ready/rd_ready stay 0 throughout.
- After init, write addr=5, strb=4'h3, data=32'hDEADBEEF -> 2 cycles later bram_wren=4'h3, bram_addr=5, bram_din=32'hDEADBEEF. wr_ready is low for exactly one cycle.
- Write addr=7 followed immediately by a read of addr=7 -> the read is not accepted until the write issues. rd_data_valid appears RD_LATENCY+1 cycles after read acceptance with the newly written value.
- Re-trigger the clear engine while an AXI write is buffered -> the clear writes take the port; the buffered write issues on the first cycle after init_wren returns to 0.
- Assert reset_n=0 one cycle after a read is accepted -> no rd_data_valid pulse; all outputs are at reset values the next cycle.
- VRAM_BOUNDS_CHECK_EN: write addr=600 -> no bram_wren and addr_err=1. A subsequent read of addr=700 -> rd_data=0 and addr_err stays 1.
